// File: rtl/instruction_fetch.sv
// 6502 fetch front end: program counter, reset/IRQ/NMI vector sequences and BRK injection.
// Optional NMI support is compiled in with `define FETCH_NMI_EN.
module instruction_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  input  logic        opcode_fetch,
  input  logic        pc_enable,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        vector_start,
  input  logic        irq,
  input  logic        nmi,
  input  logic        irq_disable,
  output logic [15:0] address_out,
  output logic [7:0]  instruction,
  output logic        sync,
  output logic [15:0] pc,
  output logic        interrupt_pending,
  output logic        busy
);

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    RUN,
    VEC_LO,
    VEC_HI
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] w_next_pc;
  logic [7:0]  r_instruction;
  logic [7:0]  w_next_instruction;
  logic [7:0]  r_vec_lo;
  logic [7:0]  w_next_vec_lo;
  logic        r_int_sel;
  logic        w_next_int_sel;
  logic        w_nmi_pending;
  logic        w_interrupt_pending;
  logic        w_inject;
  logic [15:0] w_vec_base;

`ifdef FETCH_NMI_EN
  logic r_nmi_pending;
  logic r_nmi_prev;
  logic w_nmi_edge;
  logic w_nmi_clear;

  assign w_nmi_edge  = r_nmi_prev & ~nmi;
  assign w_nmi_clear = rdy & (r_state == RUN) & vector_start & r_nmi_pending;

  // Edge detector runs every clock, independent of rdy; a fresh edge beats the clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_nmi_prev    <= 1'b1;
      r_nmi_pending <= 1'b0;
    end else begin
      r_nmi_prev <= nmi;
      if (w_nmi_edge) begin
        r_nmi_pending <= 1'b1;
      end else if (w_nmi_clear) begin
        r_nmi_pending <= 1'b0;
      end
    end
  end

  assign w_nmi_pending = r_nmi_pending;
`else
  logic w_unused_nmi;

  assign w_unused_nmi  = nmi;
  assign w_nmi_pending = 1'b0;
`endif

  // r_int_sel only ever becomes 1 when an NMI is pending, so without NMI support it stays on IRQ.
  assign w_vec_base          = r_int_sel ? NMI_VECTOR : IRQ_VECTOR;
  assign w_interrupt_pending = w_nmi_pending | (~irq & ~irq_disable);
  assign w_inject            = (r_state == RUN) & opcode_fetch & w_interrupt_pending;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state       <= RST_LO;
      r_pc          <= 16'h0000;
      r_instruction <= 8'h00;
      r_vec_lo      <= 8'h00;
      r_int_sel     <= 1'b0;
    end else if (rdy) begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_instruction <= w_next_instruction;
      r_vec_lo      <= w_next_vec_lo;
      r_int_sel     <= w_next_int_sel;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    w_next_pc          = r_pc;
    w_next_instruction = r_instruction;
    w_next_vec_lo      = r_vec_lo;
    w_next_int_sel     = r_int_sel;
    address_out        = RESET_VECTOR;
    busy               = 1'b1;
    sync               = 1'b0;

    case (r_state)
      RST_LO: begin
        address_out   = RESET_VECTOR;
        w_next_vec_lo = data_in;
        w_next_state  = RST_HI;
      end

      RST_HI: begin
        address_out  = RESET_VECTOR + 16'd1;
        w_next_pc    = {data_in, r_vec_lo};
        w_next_state = RUN;
      end

      RUN: begin
        address_out        = r_pc;
        busy               = 1'b0;
        sync               = opcode_fetch;
        w_next_instruction = w_inject ? 8'h00 : data_in;
        // An injected BRK must re-execute at the same PC, so plain increments are suppressed.
        if (pc_load) begin
          w_next_pc = pc_load_value;
        end else if (pc_enable && !w_inject) begin
          w_next_pc = r_pc + 16'd1;
        end
        if (w_inject || vector_start) begin
          w_next_int_sel = w_nmi_pending;
        end
        if (vector_start) begin
          w_next_state = VEC_LO;
        end
      end

      VEC_LO: begin
        address_out   = w_vec_base;
        w_next_vec_lo = data_in;
        w_next_state  = VEC_HI;
      end

      VEC_HI: begin
        address_out    = w_vec_base + 16'd1;
        w_next_pc      = {data_in, r_vec_lo};
        w_next_int_sel = 1'b0;
        w_next_state   = RUN;
      end

      default: begin
        w_next_state = RST_LO;
      end
    endcase
  end

  assign pc                = r_pc;
  assign instruction       = r_instruction;
  assign interrupt_pending = w_interrupt_pending;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios followed by random traffic,
// checked against a memory-backed behavioural model of the fetch unit.
module tb_instruction_fetch;

  logic        clk;
  logic        res;
  logic        rdy;
  logic [7:0]  data_in;
  logic        opcode_fetch;
  logic        pc_enable;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        vector_start;
  logic        irq;
  logic        nmi;
  logic        irq_disable;
  logic [15:0] address_out;
  logic [7:0]  instruction;
  logic        sync;
  logic [15:0] pc;
  logic        interrupt_pending;
  logic        busy;

  instruction_fetch dut (
    .clk               (clk),
    .res               (res),
    .rdy               (rdy),
    .data_in           (data_in),
    .opcode_fetch      (opcode_fetch),
    .pc_enable         (pc_enable),
    .pc_load           (pc_load),
    .pc_load_value     (pc_load_value),
    .vector_start      (vector_start),
    .irq               (irq),
    .nmi               (nmi),
    .irq_disable       (irq_disable),
    .address_out       (address_out),
    .instruction       (instruction),
    .sync              (sync),
    .pc                (pc),
    .interrupt_pending (interrupt_pending),
    .busy              (busy)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  instr;
    logic [15:0] pcv;
    logic        busyv;
    logic        syncv;
    logic        intPend;
  } obs_t;

  localparam int PH_RESET_LO = 0;
  localparam int PH_RESET_HI = 1;
  localparam int PH_RUN      = 2;
  localparam int PH_VEC_LO   = 3;
  localparam int PH_VEC_HI   = 4;

  logic [7:0] mem [0:65535];

  obs_t  expQ [$];
  string labelQ [$];
  obs_t  monExp;
  string monLabel;
  int    totalChecks;
  int    badChecks;
  string curLabel;

  // Stimulus knobs, copied onto the DUT pins once per cycle
  bit          iRes, iRdy, iOpFetch, iPcEn, iPcLoad, iVecStart, iIrq, iNmi, iIrqDis;
  logic [15:0] iPcVal;
  logic [7:0]  curData;

  // Reference model state
  int          mPhase;
  logic [15:0] mPc;
  logic [7:0]  mInstr;
  logic [7:0]  mVecLo;
  bit          mUseNmi;
  bit          mNmiPend;
  bit          mNmiPrev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] modelAddr();
    logic [15:0] base;
    base = mUseNmi ? 16'hFFFA : 16'hFFFE;
    case (mPhase)
      PH_RESET_LO: return 16'hFFFC;
      PH_RESET_HI: return 16'hFFFD;
      PH_RUN:      return mPc;
      PH_VEC_LO:   return base;
      default:     return base + 16'd1;
    endcase
  endfunction

  task automatic modelReset();
    mPhase   = PH_RESET_LO;
    mPc      = 16'h0000;
    mInstr   = 8'h00;
    mVecLo   = 8'h00;
    mUseNmi  = 1'b0;
    mNmiPend = 1'b0;
    mNmiPrev = 1'b1;
  endtask

  // Advance the model by one rising edge with reset released.
  task automatic modelStep();
    bit wantsIrq;
    bit inject;
    bit newPend;
    wantsIrq = mNmiPend || (!iIrq && !iIrqDis);
    newPend  = mNmiPend;
    if (iRdy) begin
      case (mPhase)
        PH_RESET_LO: begin
          mVecLo = curData;
          mPhase = PH_RESET_HI;
        end
        PH_RESET_HI: begin
          mPc    = {curData, mVecLo};
          mPhase = PH_RUN;
        end
        PH_RUN: begin
          inject = iOpFetch && wantsIrq;
          mInstr = inject ? 8'h00 : curData;
          if (iPcLoad) mPc = iPcVal;
          else if (iPcEn && !inject) mPc = mPc + 16'd1;
          if (iVecStart) begin
            mUseNmi = mNmiPend;
            if (mNmiPend) newPend = 1'b0;
            mPhase = PH_VEC_LO;
          end
        end
        PH_VEC_LO: begin
          mVecLo = curData;
          mPhase = PH_VEC_HI;
        end
        default: begin
          mPc     = {curData, mVecLo};
          mUseNmi = 1'b0;
          mPhase  = PH_RUN;
        end
      endcase
    end
`ifdef FETCH_NMI_EN
    if (mNmiPrev && !iNmi) newPend = 1'b1;
    mNmiPrev = iNmi;
`endif
    mNmiPend = newPend;
  endtask

  // One bus cycle: drive pins at the falling edge, queue the expected view, step the model.
  task automatic applyStimulus();
    obs_t e;
    @(negedge clk);
    if (!iRes) modelReset();
    res           = iRes;
    rdy           = iRdy;
    opcode_fetch  = iOpFetch;
    pc_enable     = iPcEn;
    pc_load       = iPcLoad;
    pc_load_value = iPcVal;
    vector_start  = iVecStart;
    irq           = iIrq;
    nmi           = iNmi;
    irq_disable   = iIrqDis;
    curData       = mem[modelAddr()];
    data_in       = curData;
    e.addr    = modelAddr();
    e.instr   = mInstr;
    e.pcv     = mPc;
    e.busyv   = (mPhase != PH_RUN);
    e.syncv   = (mPhase == PH_RUN) && iOpFetch;
    e.intPend = mNmiPend || (!iIrq && !iIrqDis);
    expQ.push_back(e);
    labelQ.push_back(curLabel);
    @(posedge clk);
    if (iRes) modelStep();
  endtask

  task automatic checkOutput(input obs_t exp, input string lbl);
    obs_t got;
    got.addr    = address_out;
    got.instr   = instruction;
    got.pcv     = pc;
    got.busyv   = busy;
    got.syncv   = sync;
    got.intPend = interrupt_pending;
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s @%0t: got addr=%h instr=%h pc=%h busy=%b sync=%b ip=%b, want addr=%h instr=%h pc=%h busy=%b sync=%b ip=%b",
               lbl, $time, got.addr, got.instr, got.pcv, got.busyv, got.syncv, got.intPend,
               exp.addr, exp.instr, exp.pcv, exp.busyv, exp.syncv, exp.intPend);
    end
  endtask

  // Monitor: samples settled outputs after the driver has updated the pins
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        monExp   = expQ.pop_front();
        monLabel = labelQ.pop_front();
        checkOutput(monExp, monLabel);
      end
    end
  end

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    res = 1'b0; rdy = 1'b1; data_in = 8'h00; opcode_fetch = 1'b0; pc_enable = 1'b0;
    pc_load = 1'b0; pc_load_value = 16'h0000; vector_start = 1'b0; irq = 1'b1;
    nmi = 1'b1; irq_disable = 1'b0;
    iRes = 1'b0; iRdy = 1'b1; iOpFetch = 1'b0; iPcEn = 1'b0; iPcLoad = 1'b0;
    iVecStart = 1'b0; iIrq = 1'b1; iNmi = 1'b1; iIrqDis = 1'b0; iPcVal = 16'h0000;
    modelReset();

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h06; mem[16'h8001] = 8'h10;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    $display("[TB] starting instruction_fetch bench");

    curLabel = "reset";
    runCycles(2);
    iRes = 1'b1;
    runCycles(1);
    curLabel = "stall_rst_hi";
    iRdy = 1'b0;
    runCycles(3);
    iRdy = 1'b1;
    runCycles(1);

    curLabel = "fetch";
    iPcEn = 1'b1; iOpFetch = 1'b1;
    runCycles(3);

    curLabel = "pc_load_priority";
    iPcLoad = 1'b1; iPcVal = 16'h1234;
    runCycles(1);
    curLabel = "pc_wrap";
    iPcVal = 16'hFFFF;
    runCycles(1);
    iPcLoad = 1'b0;
    runCycles(2);

    curLabel = "irq_inject";
    iIrq = 1'b0; iIrqDis = 1'b0; iOpFetch = 1'b1; iPcEn = 1'b1;
    runCycles(1);
    curLabel = "irq_vector";
    iOpFetch = 1'b0; iPcEn = 1'b0; iVecStart = 1'b1;
    runCycles(1);
    iVecStart = 1'b0;
    runCycles(3);
    curLabel = "irq_masked";
    iIrqDis = 1'b1; iOpFetch = 1'b1; iPcEn = 1'b1;
    runCycles(2);
    iIrq = 1'b1; iIrqDis = 1'b0; iOpFetch = 1'b0; iPcEn = 1'b0;

`ifdef FETCH_NMI_EN
    curLabel = "nmi_hijack";
    iIrq = 1'b0; iOpFetch = 1'b1;
    runCycles(1);
    iIrq = 1'b1; iOpFetch = 1'b0; iNmi = 1'b0;
    runCycles(1);
    iVecStart = 1'b1;
    runCycles(1);
    iVecStart = 1'b0; iNmi = 1'b1;
    runCycles(3);
`endif

    curLabel = "reset_mid_vec";
    iVecStart = 1'b1;
    runCycles(1);
    iVecStart = 1'b0;
    runCycles(1);
    iRes = 1'b0;
    runCycles(1);
    iRes = 1'b1;
    runCycles(3);

    curLabel = "random";
    for (int n = 0; n < 3000; n++) begin
      iRes      = ($urandom_range(0, 199) != 0);
      iRdy      = ($urandom_range(0, 9) < 8);
      iOpFetch  = 1'($urandom);
      iPcEn     = 1'($urandom);
      iPcLoad   = ($urandom_range(0, 9) == 0);
      iPcVal    = 16'($urandom);
      iVecStart = ($urandom_range(0, 19) == 0);
      iIrq      = ($urandom_range(0, 9) < 7);
      iIrqDis   = 1'($urandom);
      iNmi      = ($urandom_range(0, 9) < 8);
      applyStimulus();
    end

    repeat (2) @(negedge clk);
    #5;
    totalChecks++;
    if (expQ.size() != 0) begin
      badChecks++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front end of the 6502 core and producer of the `instruction` byte consumed by the decoder. Owns the program counter and the reset/interrupt vector fetch sequences. Drives the fetch address onto the external bus and latches returned bytes. Injects a BRK (0x00) opcode when an interrupt is pending at an opcode boundary.

Parameters:
RESET_VECTOR, 16'hFFFC, low-byte address of the reset vector
IRQ_VECTOR, 16'hFFFE, low-byte address of the IRQ/BRK vector
NMI_VECTOR, 16'hFFFA, low-byte address of the NMI vector

Ports:
clk  in  1  core clock; all state updates on the rising edge
res  in  1  reset, asynchronous, active-low
rdy  in  1  bus ready; 0 freezes the block
data_in  in  8  external data bus read value
opcode_fetch  in  1  decoder is in T_0 (current byte is an opcode)
pc_enable  in  1  increment PC this cycle
pc_load  in  1  load PC from pc_load_value (jumps/branches)
pc_load_value  in  16  new PC value
vector_start  in  1  decoder BRK sequence requests the vector fetch
irq  in  1  interrupt request, active-low, level
nmi  in  1  non-maskable interrupt, active-low, falling edge
irq_disable  in  1  I flag from the status register
address_out  out  16  fetch address
instruction  out  8  latched byte for the decoder
sync  out  1  opcode-fetch cycle indicator
pc  out  16  current program counter
interrupt_pending  out  1  IRQ or NMI awaiting service
busy  out  1  vector sequence in progress

Behaviour:
- States: RST_LO, RST_HI, RUN, VEC_LO, VEC_HI.
- Reset (res=0, asynchronous): state=RST_LO, pc=0000, instruction=00, vec_lo=00, nmi_pending=0, nmi_prev=1, int_sel=IRQ.
- Reset outputs: address_out=RESET_VECTOR, busy=1, sync=0.
- Reset mid-sequence or mid-RUN aborts immediately to RST_LO.
- rdy=0 freezes state, pc, instruction and vec_lo. The nmi edge detector keeps sampling while rdy=0.
- RST_LO: address_out=RESET_VECTOR; on the edge, vec_lo<=data_in; next RST_HI.
- RST_HI: address_out=RESET_VECTOR+1; on the edge, pc<={data_in,vec_lo}; next RUN.
- RUN, address: address_out=pc (combinational); busy=0; sync=opcode_fetch.
- RUN, each rdy edge: instruction<=data_in. PC priority is pc_load > pc_enable > hold; increment wraps FFFF->0000.
- Interrupt pending: interrupt_pending = nmi_pending | (~irq & ~irq_disable).
- nmi_pending is set when nmi_prev=1 and nmi=0; nmi_prev is registered every clock.
- Injection: in RUN, on a rdy edge with opcode_fetch=1 and interrupt_pending=1:
  - instruction<=00 (BRK);
  - pc is held, even if pc_enable=1 (pc_load still wins);
  - int_sel<=NMI if nmi_pending, else IRQ.
- Vector select: vector_start in RUN -> VEC_LO. Base = NMI_VECTOR if nmi_pending is still set at this edge (NMI hijack of IRQ/BRK), else IRQ_VECTOR. Software BRK (no injection) uses IRQ_VECTOR.
- nmi_pending clears on entry to VEC_LO when NMI_VECTOR is selected.
- VEC_LO: address_out=base; vec_lo<=data_in; next VEC_HI.
- VEC_HI: address_out=base+1; pc<={data_in,vec_lo}; int_sel<=IRQ; next RUN.
- Outside RUN, pc_enable, pc_load, opcode_fetch and vector_start are ignored. busy=1 in every state other than RUN.

Optional Feature:
FETCH_NMI_EN.
- Defined: NMI edge detection, nmi_pending, NMI_VECTOR selection and hijack as described above.
- Undefined: nmi is ignored and nmi_pending is constant 0. interrupt_pending = ~irq & ~irq_disable, and every vector fetch uses IRQ_VECTOR.

Test Plan:
1. Reset: res=0 then 1, with memory FFFC=00, FFFD=80 -> address_out FFFC then FFFD; pc=8000 after 2 rdy edges; busy 1->0.
2. Fetch: pc=8000, pc_enable=1, data 06,10 -> address_out 8000,8001,8002; instruction 06 then 10.
3. Stall and PC rules:
   - rdy=0 for 3 cycles in RST_HI -> address_out stays FFFD, pc unchanged.
   - pc=FFFF with pc_enable -> pc=0000.
   - pc_load=1, pc_enable=1, value 1234 -> pc=1234.
4. IRQ:
   - irq=0, irq_disable=0, opcode_fetch=1 -> instruction=00, pc held.
   - vector_start with FFFE=34, FFFF=12 -> pc=1234.
   - Repeat with irq_disable=1 -> normal fetch, no injection.
5. NMI hijack (FETCH_NMI_EN): IRQ injected, then nmi falls before vector_start -> vector read from FFFA/FFFB; nmi_pending clears.
6. Reset mid-VEC_HI: res=0 -> state RST_LO, address_out=FFFC, instruction=00.
